// File: rtl/wam_mol.sv
// rtl/wam_mol.sv - mole field engine: spawns, ages out and judges hits on 16 holes
//
// Optional feature macro: WAM_MOL_PAUSE_EN (adds the pause input)
//
// Ports:
//   clk_19    in   1   game clock, rising edge
//   start     in   1   synchronous active-high reset / new game
//   tick      in   1   one-cycle game-step enable
//   age       in   4   mole lifetime in ticks (0 treated as 1)
//   rto       in   8   spawn threshold
//   hit       in  16   per-hole touch pulses
//   pause     in   1   freeze play (only with WAM_MOL_PAUSE_EN)
//   mole      out 16   visible moles
//   live_cnt  out  3   popcount of mole, saturated to 7
//   hit_ok    out  1   at least one valid hit this cycle
//   hit_num   out  5   number of valid hits this cycle
//   whiff     out  1   a touch landed on an empty hole
//   miss      out  1   at least one mole expired unhit

module wam_mol #(
    parameter int          NHOLE   = 16,
    parameter int          MAXLIVE = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk_19,
    input  logic        start,
    input  logic        tick,
    input  logic [3:0]  age,
    input  logic [7:0]  rto,
    input  logic [15:0] hit,
`ifdef WAM_MOL_PAUSE_EN
    input  logic        pause,
`endif
    output logic [15:0] mole,
    output logic [2:0]  live_cnt,
    output logic        hit_ok,
    output logic [4:0]  hit_num,
    output logic        whiff,
    output logic        miss
);

    // Hole index is 4 bits, so the field is always 16 wide.
    localparam int NH = 16;

    // Per-hole remaining lifetime; 0 means the hole is empty.
    logic [3:0]  cnt   [NH];
    logic [3:0]  cnt_n [NH];
    logic [15:0] lfsr;
    logic [15:0] lfsr_n;

    logic        run;
    logic        tick_e;
    logic [15:0] hit_e;
    logic [3:0]  idx;
    logic [7:0]  rnd;
    logic [3:0]  age_eff;
    logic        spawn_ok;
    logic        live_lt_max;
    logic [15:0] hit_v;
    logic [15:0] mole_n;
    logic        whiff_n;
    logic        miss_n;
    logic [4:0]  live_sum;
    logic [4:0]  hit_sum;
    logic [2:0]  live_n;

    always_comb begin
`ifdef WAM_MOL_PAUSE_EN
        run = ~pause;
`else
        run = 1'b1;
`endif
        tick_e  = tick & run;
        hit_e   = hit & {16{run}};

        // Draws come from the pre-advance LFSR value.
        idx     = lfsr[3:0];
        rnd     = lfsr[15:8];
        age_eff = (age == 4'd0) ? 4'd1 : age;

        // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10.
        lfsr_n  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

        hit_v   = '0;
        whiff_n = 1'b0;
        miss_n  = 1'b0;
        for (int i = 0; i < NH; i++) begin
            cnt_n[i] = cnt[i];
            if (hit_e[i] && (cnt[i] != 4'd0)) begin
                // A hit beats expiry on the same cycle: no miss for this hole.
                cnt_n[i] = 4'd0;
                hit_v[i] = 1'b1;
            end else if (hit_e[i]) begin
                whiff_n = 1'b1;
            end else if (tick_e && (cnt[i] != 4'd0)) begin
                if (cnt[i] == 4'd1) begin
                    cnt_n[i] = 4'd0;
                    miss_n   = 1'b1;
                end else begin
                    cnt_n[i] = cnt[i] - 4'd1;
                end
            end
        end

        // Occupancy limit uses the registered count, not the post-hit count.
        live_lt_max = (32'(live_cnt) < MAXLIVE);
        spawn_ok    = tick_e && (cnt[idx] == 4'd0) && !hit_e[idx] &&
                      (rnd < rto) && live_lt_max;
        // idx is empty at cycle start, so nothing above touched cnt_n[idx].
        if (spawn_ok) begin
            cnt_n[idx] = age_eff;
        end

        live_sum = '0;
        hit_sum  = '0;
        for (int i = 0; i < NH; i++) begin
            mole_n[i] = (cnt_n[i] != 4'd0);
            live_sum  = live_sum + 5'(mole_n[i]);
            hit_sum   = hit_sum + 5'(hit_v[i]);
        end
        live_n = (live_sum > 5'd7) ? 3'd7 : live_sum[2:0];
    end

    always_ff @(posedge clk_19) begin
        if (start) begin
            for (int i = 0; i < NH; i++) begin
                cnt[i] <= 4'd0;
            end
            lfsr     <= SEED;
            mole     <= '0;
            live_cnt <= '0;
            hit_ok   <= 1'b0;
            hit_num  <= '0;
            whiff    <= 1'b0;
            miss     <= 1'b0;
        end else begin
            for (int i = 0; i < NH; i++) begin
                cnt[i] <= cnt_n[i];
            end
            lfsr     <= lfsr_n;
            mole     <= mole_n;
            live_cnt <= live_n;
            hit_ok   <= (hit_sum != 5'd0);
            hit_num  <= hit_sum;
            whiff    <= whiff_n;
            miss     <= miss_n;
        end
    end

endmodule
